program_counter: RTL and testbench

- 32-bit program counter for the RV32 core; drives the instruction-fetch address.
- Holds the current instruction address and advances it by 4 on a sequential step, or loads a jump/branch target.
- Detects terminal conditions and raises a sticky halt that freezes fetch until reset.

---
 rtl/program_counter.sv | 67 ++++++
 tb/tb_program_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// RV32 program counter: sequential step, jump load, sticky halt.
// Drives the instruction-fetch address; halt freezes fetch until reset.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic        imm,
  input  logic [31:0] imm_addr,
  output logic [31:0] instr_addr,
  output logic        halt
);

  localparam logic [32:0] LO = {1'b0, RESET_ADDR};
  localparam logic [32:0] HI = {1'b0, RESET_ADDR}
                             + {1'b0, IMEM_BYTES};

  logic [31:0] addr_q, addr_d;
  logic        halt_q, halt_d;
  logic [31:0] nxt;
  logic [32:0] nxt_w;
  logic        misal;
  logic        oor;
  logic        selfj;
  logic        stop;

  // Next-address candidate and the three terminal conditions.
  always_comb begin
    nxt   = imm ? imm_addr : addr_q + 32'd4;
    nxt_w = {1'b0, nxt};
    misal = nxt[1:0] != 2'b00;
    oor   = (nxt_w < LO) || (nxt_w >= HI);
    selfj = imm && (imm_addr == addr_q);
    stop  = misal || oor || selfj;
  end

  // Advance only when enabled and not halted; a bad target halts
  // without ever presenting the offending address.
  always_comb begin
    addr_d = addr_q;
    halt_d = halt_q;
    if (!halt_q && we) begin
      if (stop) begin
        halt_d = 1'b1;
      end else begin
        addr_d = nxt;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q <= RESET_ADDR;
      halt_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      halt_q <= halt_d;
    end
  end

  assign instr_addr = addr_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// Directed plan followed by randomized steps against a reference model.
module tb_program_counter;

  localparam logic [31:0] RST = 32'h0000_0000;
  localparam logic [31:0] MEM = 32'h0000_1000;

  logic        clk;
  logic        rstn;
  logic        we;
  logic        imm;
  logic [31:0] imm_addr;
  logic [31:0] instr_addr;
  logic        halt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_addr;
  logic        m_halt;

  program_counter #(
    .RESET_ADDR(RST),
    .IMEM_BYTES(MEM)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .we        (we),
    .imm       (imm),
    .imm_addr  (imm_addr),
    .instr_addr(instr_addr),
    .halt      (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the behavioural rules, written with plain integer math.
  task automatic model(input logic r, input logic w,
                       input logic i, input logic [31:0] a);
    longint unsigned t;
    bit bad;
    if (!r) begin
      m_addr = RST;
      m_halt = 1'b0;
    end else if (!m_halt && w) begin
      t = i ? longint'(a) : (longint'(m_addr) + 4) % (64'd1 << 32);
      bad = (t % 4 != 0)
         || (t < longint'(RST))
         || (t >= longint'(RST) + longint'(MEM))
         || (i && a == m_addr);
      if (bad) m_halt = 1'b1;
      else     m_addr = t[31:0];
    end
  endtask

  task automatic chk(input string tag);
    checks++;
    assert (instr_addr === m_addr && halt === m_halt) else begin
      errors++;
      $error("FAIL %s: got addr=%h halt=%b, want addr=%h halt=%b",
             tag, instr_addr, halt, m_addr, m_halt);
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] ea,
                     input logic eh);
    checks++;
    assert (instr_addr === ea && halt === eh) else begin
      errors++;
      $error("FAIL %s: got addr=%h halt=%b, want addr=%h halt=%b",
             tag, instr_addr, halt, ea, eh);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic w,
                      input logic i, input logic [31:0] a);
    @(negedge clk);
    rstn = r; we = w; imm = i; imm_addr = a;
    @(posedge clk);
    model(r, w, i, a);
    #1;
    chk(tag);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    logic r, w, i;
    rstn = 1'b0; we = 1'b0; imm = 1'b0; imm_addr = '0;
    m_addr = RST; m_halt = 1'b0;

    step("rst0", 0, 1, 1, 32'h40);
    step("rst1", 0, 1, 1, 32'h40);
    lit("rst_val", 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) step("idle", 1, 0, 0, 32'h0);
    lit("idle_hold", 32'h0, 1'b0);

    step("seq4", 1, 1, 0, 32'h0);
    lit("seq4_lit", 32'h4, 1'b0);
    step("seq8", 1, 1, 0, 32'h0);
    step("seqC", 1, 1, 0, 32'h0);
    step("seq10", 1, 1, 0, 32'h0);
    lit("seq10_lit", 32'h10, 1'b0);
    step("hold10", 1, 0, 0, 32'h0);
    lit("hold10_lit", 32'h10, 1'b0);

    step("jmp100", 1, 1, 1, 32'h100);
    lit("jmp100_lit", 32'h100, 1'b0);
    step("seq104", 1, 1, 0, 32'h0);
    step("wex", 1, 0, 1, 32'h200);
    lit("we0_hold", 32'h104, 1'b0);
    step("xin", 1, 0, 1'bx, 32'hxxxx_xxxx);
    lit("x_hold", 32'h104, 1'b0);

    step("misal", 1, 1, 1, 32'h106);
    lit("misal_lit", 32'h104, 1'b1);

    step("rstA", 0, 0, 0, 32'h0);
    step("oor", 1, 1, 1, 32'h1000);
    lit("oor_lit", 32'h0, 1'b1);

    step("rstB", 0, 0, 0, 32'h0);
    step("s4", 1, 1, 0, 32'h0);
    step("s8", 1, 1, 0, 32'h0);
    step("selfj", 1, 1, 1, 32'h8);
    lit("selfj_lit", 32'h8, 1'b1);

    step("rstC", 0, 0, 0, 32'h0);
    for (int k = 0; k < 1023; k++) step("walk", 1, 1, 0, 32'h0);
    lit("end_ffc", 32'hFFC, 1'b0);
    step("end", 1, 1, 0, 32'h0);
    lit("end_halt", 32'hFFC, 1'b1);

    step("stk0", 1, 1, 0, 32'h0);
    step("stk1", 1, 1, 1, 32'h20);
    step("stk2", 1, 1, 1, 32'hFFC);
    lit("sticky", 32'hFFC, 1'b1);
    step("rec", 0, 1, 1, 32'h40);
    lit("rec_lit", 32'h0, 1'b0);
    step("rec4", 1, 1, 0, 32'h0);
    lit("rec4_lit", 32'h4, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    a = {20'h0, $urandom_range(0, 1023) , 2'b00};
        2:       a = m_addr;
        3:       a = $urandom;
        4:       a = {20'h0, 10'($urandom_range(0, 1023)),
                      2'($urandom_range(1, 3))};
        default: a = m_addr + 32'd4;
      endcase
      r = m_halt ? ($urandom_range(0, 3) != 0)
                 : ($urandom_range(0, 49) != 0);
      w = $urandom_range(0, 3) != 0;
      i = $urandom_range(0, 2) == 0;
      step("rand", r, w, i, a);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
